// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants and the field bundle carried through the encoder pipeline.
package rv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] JAL    = 5'b11011;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when v[31:k] are all copies of one bit, i.e. v fits a (k+1)-bit signed field.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned k);
    logic [31:0] s;
    s = 32'($signed(v) >>> k);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range check.
module instr_pack
  import rv_enc_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] ir,
  output logic        err
);

  logic [24:0] hi;

  always_comb begin
    hi  = '0;
    err = 1'b0;
    ir  = NOP_IR;
    case (f.fmt)
      FMT_R: hi = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd};
      FMT_I: begin
        hi  = {f.imm[11:0], f.rs1, f.funct3, f.rd};
        err = !sext_fits(f.imm, 11);
      end
      FMT_S: begin
        hi  = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0]};
        err = !sext_fits(f.imm, 11);
      end
      FMT_B: begin
        hi  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11]};
        err = !sext_fits(f.imm, 12) || f.imm[0];
      end
      FMT_U: begin
        hi  = {f.imm[31:12], f.rd};
        err = |f.imm[11:0];
      end
      FMT_J: begin
        hi  = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd};
        err = !sext_fits(f.imm, 20) || f.imm[0];
      end
      default: err = 1'b1;
    endcase
    // Illegal formats emit a canonical NOP rather than a half-built word.
    if (f.fmt <= FMT_J) ir = {hi, f.opcode, 2'b11};
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 holds fields, S2 holds ir/err/addr.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  fields_t           s1_q;
  logic              s1_valid_q;
  logic              out_valid_q;
  logic [31:0]       ir_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;

  logic [31:0] pack_ir;
  logic        pack_err;
  logic        advance;
  logic        accept;
  logic        out_fire;

  instr_pack u_pack (
    .f   (s1_q),
    .ir  (pack_ir),
    .err (pack_err)
  );

  always_comb begin
    advance  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !rst && !flush && (!s1_valid_q || advance);
    accept   = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ir_q        <= '0;
      err_q       <= 1'b0;
      addr_q      <= BaseAddr;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= BaseAddr;
    end else begin
      if (accept) s1_q <= '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                             funct3: funct3, funct7: funct7, imm: imm};
      s1_valid_q <= accept || (s1_valid_q && !advance);
      if (advance) begin
        ir_q  <= pack_ir;
        err_q <= pack_err;
      end
      out_valid_q <= advance || (out_valid_q && !out_ready);
      // addr names the word currently in S2, so it moves only when that word leaves.
      if (out_fire) addr_q <= addr_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign ir        = ir_q;
  assign err       = err_q;
  assign addr      = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven, scoreboard-checked bench for instr_encoder (8-bit and 2-bit address instances).
module tb_instr_encoder;
  import rv_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  fmt, funct3;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        in_ready, out_valid, err;
  logic [31:0] ir;
  logic [7:0]  addr;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_ir;
  logic [1:0]  w_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .ir(ir), .addr(addr), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(w_out_valid), .out_ready(out_ready),
    .ir(w_ir), .addr(w_addr), .err(w_err)
  );

  typedef struct {
    logic [2:0] fmt; logic [4:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm; logic [31:0] ir; logic err;
  } vec_t;
  typedef struct { logic [31:0] ir; logic err; int acc_cyc; bit lat; } exp_t;

  vec_t        vecs[15];
  exp_t        sb[$];
  int          n_err = 0, n_chk = 0, cyc = 0, exp_addr = 0, cur = 0;
  bit          acc, lat_mode, stalled;
  logic [31:0] hold_ir;
  logic [7:0]  hold_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic apply(input int i);
    cur = i; in_valid = 1'b1;
    fmt = vecs[i].fmt; opcode = vecs[i].op; rd = vecs[i].rd; rs1 = vecs[i].rs1;
    rs2 = vecs[i].rs2; funct3 = vecs[i].f3; funct7 = vecs[i].f7; imm = vecs[i].imm;
  endtask

  // One clock: sample at negedge (scoreboard), then advance past posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (rst || flush) begin
      check("in_ready_low_rst_flush", {31'd0, in_ready}, 32'd0);
      sb.delete();
      exp_addr = 0;
      stalled  = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_ir", ir, hold_ir);
        check("stall_addr", {24'd0, addr}, {24'd0, hold_addr});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          e = sb.pop_front();
          check("ir", ir, e.ir);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("addr", {24'd0, addr}, 32'(exp_addr % 256));
          check("w_addr", {30'd0, w_addr}, 32'(exp_addr % 4));
          check("w_ir", w_ir, e.ir);
          if (e.lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
        end
        exp_addr++;
      end
      stalled   = out_valid && !out_ready;
      hold_ir   = ir;
      hold_addr = addr;
      if (in_valid && in_ready) begin
        sb.push_back('{ir: vecs[cur].ir, err: vecs[cur].err, acc_cyc: cyc, lat: lat_mode});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int first, input int n);
    int i = first;
    int budget = 0;
    while (i < first + n && budget < 60) begin
      apply(i);
      step();
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0;
    if (i < first + n) fail_now("send");
  endtask

  task automatic drain();
    int budget = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && budget < 30) begin
      step();
      budget++;
    end
    if (sb.size() != 0 || out_valid) fail_now("drain");
  endtask

  initial begin
    int idx;
    int n_acc;
    //           fmt    op      rd  rs1 rs2 f3  f7     imm            ir             err
    vecs[0]  = '{FMT_I, OP_IMM, 1,  0,  0,  0,  0,     32'd5,         32'h00500093, 0};
    vecs[1]  = '{FMT_R, OP,     3,  1,  2,  0,  0,     32'd0,         32'h002081B3, 0};
    vecs[2]  = '{FMT_B, BRANCH, 0,  1,  2,  0,  0,     32'hFFFFFFFC,  32'hFE208EE3, 0};
    vecs[3]  = '{FMT_U, LUI,    5,  0,  0,  0,  0,     32'h12345000,  32'h123452B7, 0};
    vecs[4]  = '{FMT_I, OP_IMM, 1,  0,  0,  0,  0,     32'h00000800,  32'h80000093, 1};
    vecs[5]  = '{3'd7,  OP_IMM, 1,  0,  0,  0,  0,     32'd5,         32'h00000013, 1};
    vecs[6]  = '{FMT_S, STORE,  0,  2,  3,  2,  0,     32'd8,         32'h00312423, 0};
    vecs[7]  = '{FMT_J, JAL,    1,  0,  0,  0,  0,     32'd8,         32'h008000EF, 0};
    vecs[8]  = '{FMT_J, JAL,    1,  0,  0,  0,  0,     32'd3,         32'h002000EF, 1};
    vecs[9]  = '{FMT_U, LUI,    0,  0,  0,  0,  0,     32'h00001001,  32'h00001037, 1};
    vecs[10] = '{FMT_B, BRANCH, 0,  0,  0,  0,  0,     32'd1,         32'h00000063, 1};
    vecs[11] = '{FMT_I, OP_IMM, 2,  2,  0,  0,  0,     32'hFFFFFFFF,  32'hFFF10113, 0};
    vecs[12] = '{3'd6,  OP,     7,  7,  7,  7,  7'h7F, 32'd0,         32'h00000013, 1};
    vecs[13] = '{FMT_R, OP,     3,  1,  2,  0,  7'h20, 32'hDEADBEEF,  32'h402081B3, 0};
    vecs[14] = '{FMT_J, JAL,    0,  0,  0,  0,  0,     32'h00100000,  32'h8000006F, 1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; lat_mode = 1'b0; stalled = 1'b0;
    apply(0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single addi: exact 2-cycle latency, addr 0.
    lat_mode = 1'b1;
    send(0, 1);
    drain();

    // Restart addressing, then stream the table back-to-back (2-bit instance wraps).
    flush = 1'b1;
    step();
    flush = 1'b0;
    send(1, 14);
    drain();

    // Backpressure: 3 words offered over 4 stalled cycles.
    lat_mode = 1'b0;
    out_ready = 1'b0;
    idx = 6;
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      apply(idx);
      step();
      if (acc) begin idx++; n_acc++; end
    end
    check("bp_accepts", 32'(n_acc), 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    send(idx, 9 - idx);
    drain();

    // Flush with both stages full.
    out_ready = 1'b0;
    send(1, 2);
    check("full_before_flush", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(3, 1);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(6, 2);
    check("full_before_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_ir", ir, 32'd0);
    out_ready = 1'b1;
    send(7, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
